// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and width.
package serial_subtractor_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level full-subtractor cell: diff = x^y^bin, bout = ~x&y | ~(x^y)&bin.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic xy;
    logic nx;
    logic nxy;
    logic t1;
    logic t2;

    xor g_xy   (xy, x, y);
    xor g_diff (diff, xy, bin);
    not g_nx   (nx, x);
    and g_t1   (t1, nx, y);
    not g_nxy  (nxy, xy);
    and g_t2   (t2, nxy, bin);
    or  g_bout (bout, t1, t2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with start/ready/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] r_sh_reg;
    logic [WIDTH-1:0] r_sh_next;
    logic             borrow_reg;
    logic [CNTW-1:0]  cnt_reg;
    logic [WIDTH-1:0] d_reg;
    logic             bo_reg;

    logic diff;
    logic bout;
    logic load;
    logic shift_en;
    logic last_bit;

    full_subtractor u_fs (
        .x    (a_sh_reg[0]),
        .y    (b_sh_reg[0]),
        .bin  (borrow_reg),
        .diff (diff),
        .bout (bout)
    );

    // Result register fills from the top; also covers WIDTH=1 where it is just diff.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_rsh
            assign r_sh_next[gi] = r_sh_reg[gi+1];
        end
    endgenerate
    assign r_sh_next[WIDTH-1] = diff;

    assign last_bit = (cnt_reg == CNTW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;
        case (state_reg)
            S_SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                // IDLE, and the unused 11 encoding behaves identically
                ready = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = S_SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            r_sh_reg   <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            d_reg      <= '0;
            bo_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                a_sh_reg   <= a;
                b_sh_reg   <= b;
                borrow_reg <= 1'b0;
                cnt_reg    <= '0;
            end
            if (shift_en) begin
                a_sh_reg   <= a_sh_reg >> 1;
                b_sh_reg   <= b_sh_reg >> 1;
                r_sh_reg   <= r_sh_next;
                borrow_reg <= bout;
                cnt_reg    <= cnt_reg + CNTW'(1);
                // Outputs update on entry to DONE so they are valid while done is high
                if (last_bit) begin
                    d_reg  <= r_sh_next;
                    bo_reg <= bout;
                end
            end
        end
    end

    assign d  = d_reg;
    assign bo = bo_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH 4, 8 and 1.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, d4;
    logic       ready4, done4, bo4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, d8;
    logic       ready8, done8, bo8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, d1;
    logic       ready1, done1, bo1;

    serial_subtractor #(.WIDTH(4), .CNTW(3)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .done(done4), .d(d4), .bo(bo4)
    );

    serial_subtractor #(.WIDTH(8), .CNTW(4)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .done(done8), .d(d8), .bo(bo8)
    );

    serial_subtractor #(.WIDTH(1), .CNTW(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .ready(ready1), .done(done1), .d(d1), .bo(bo1)
    );

    // Each opN issues one start when ready and returns at the negedge where done is high.
    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] d, output logic bo, output int lat);
        int guard = 0;
        while (ready4 !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a4 = a; b4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done4 !== 1'b1 && lat < 50);
        d = d4; bo = bo4;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] d, output logic bo, output int lat);
        int guard = 0;
        while (ready8 !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done8 !== 1'b1 && lat < 50);
        d = d8; bo = bo8;
    endtask

    task automatic op1(input logic a, input logic b,
                       output logic d, output logic bo, output int lat);
        int guard = 0;
        while (ready1 !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a1 = a; b1 = b; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done1 !== 1'b1 && lat < 50);
        d = d1[0]; bo = bo1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({ready4, done4, d4, bo4} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset4: ready=%b done=%b d=%h bo=%b, need 1 0 0 0", ready4, done4, d4, bo4);
        end
        tests++;
        if ({ready8, done8, d8, bo8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL reset8: ready=%b done=%b d=%h bo=%b, need 1 0 0 0", ready8, done8, d8, bo8);
        end
        $display("[TB] reset: ready4=%b done4=%b d4=%h bo4=%b", ready4, done4, d4, bo4);
    endtask

    task automatic test_basic();
        logic [3:0] d;
        logic       bo;
        int         lat;
        op4(4'd9, 4'd3, d, bo, lat);
        tests++;
        if (lat != 5 || d !== 4'd6 || bo !== 1'b0) begin
            fails++;
            $display("FAIL basic_9m3: lat=%0d d=%0d bo=%b, need lat=5 d=6 bo=0", lat, d, bo);
        end
        @(negedge clk);
        tests++;
        if (ready4 !== 1'b1 || done4 !== 1'b0 || d4 !== 4'd6) begin
            fails++;
            $display("FAIL basic_after: ready=%b done=%b d=%0d, need 1 0 6", ready4, done4, d4);
        end
        $display("[TB] basic: 9-3 lat=%0d d=%0d bo=%b", lat, d, bo);
    endtask

    task automatic test_vectors();
        logic [3:0] va [3] = '{4'd3, 4'd15, 4'd0};
        logic [3:0] vb [3] = '{4'd9, 4'd15, 4'd15};
        logic [3:0] ed [3] = '{4'hA, 4'h0, 4'h1};
        logic       eb [3] = '{1'b1, 1'b0, 1'b1};
        logic [3:0] d;
        logic       bo;
        int         lat;
        for (int i = 0; i < 3; i++) begin
            op4(va[i], vb[i], d, bo, lat);
            tests++;
            if (lat != 5 || d !== ed[i] || bo !== eb[i]) begin
                fails++;
                $display("FAIL vec_%0d: a=%0d b=%0d lat=%0d d=%h bo=%b, need lat=5 d=%h bo=%b",
                         i, va[i], vb[i], lat, d, bo, ed[i], eb[i]);
            end
            $display("[TB] vector: %0d-%0d d=%h bo=%b", va[i], vb[i], d, bo);
        end
    endtask

    task automatic test_ignore();
        int         ndone = 0;
        logic [3:0] first_d = 'x;
        logic       first_bo = 1'bx;
        int         guard = 0;
        while (ready4 !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a4 = 4'd9; b4 = 4'd3; start4 = 1'b1;
        @(posedge clk); #1;
        a4 = 4'd5; b4 = 4'd12;
        repeat (3) @(posedge clk);
        #1 start4 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    first_d = d4;
                    first_bo = bo4;
                end
            end
        end
        tests++;
        if (ndone != 1 || first_d !== 4'd6 || first_bo !== 1'b0) begin
            fails++;
            $display("FAIL ignore: dones=%0d d=%h bo=%b, need 1 pulse d=6 bo=0", ndone, first_d, first_bo);
        end
        tests++;
        if (d4 !== 4'd6 || ready4 !== 1'b1) begin
            fails++;
            $display("FAIL ignore_hold: d=%h ready=%b, need d=6 ready=1", d4, ready4);
        end
        $display("[TB] ignore: dones=%0d d=%h bo=%b", ndone, first_d, first_bo);
    endtask

    task automatic test_reset_mid();
        int         ndone = 0;
        logic [3:0] d;
        logic       bo;
        int         lat;
        a4 = 4'd3; b4 = 4'd9; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (ready4 !== 1'b1 || d4 !== 4'd0 || bo4 !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_state: ready=%b d=%h bo=%b, need 1 0 0", ready4, d4, bo4);
        end
        for (int i = 0; i < 8; i++) begin
            if (done4 === 1'b1) ndone++;
            @(negedge clk);
        end
        tests++;
        if (ndone != 0) begin
            fails++;
            $display("FAIL rst_mid_nodone: dones=%0d, need 0", ndone);
        end
        op4(4'd12, 4'd5, d, bo, lat);
        tests++;
        if (lat != 5 || d !== 4'd7 || bo !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_after: lat=%0d d=%0d bo=%b, need lat=5 d=7 bo=0", lat, d, bo);
        end
        $display("[TB] reset_mid: dones=%0d then 12-5 d=%0d bo=%b", ndone, d, bo);
    endtask

    task automatic test_width8_sweep();
        logic [7:0] d;
        logic       bo;
        int         lat;
        logic [8:0] full;
        int         nerr = 0;
        for (int ai = 0; ai < 256; ai += 15) begin
            for (int bi = 0; bi < 256; bi += 15) begin
                full = {1'b0, 8'(ai)} - {1'b0, 8'(bi)};
                op8(8'(ai), 8'(bi), d, bo, lat);
                tests++;
                if (lat != 9 || d !== full[7:0] || bo !== (ai < bi)) begin
                    fails++;
                    nerr++;
                    $display("FAIL sweep8: a=%0d b=%0d lat=%0d d=%0d bo=%b, need lat=9 d=%0d bo=%b",
                             ai, bi, lat, d, bo, full[7:0], (ai < bi));
                end
            end
        end
        $display("[TB] sweep8: 324 operations, %0d wrong", nerr);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [6] = '{8'd200, 8'd1, 8'd0, 8'd128, 8'd77, 8'd255};
        logic [7:0] pb [6] = '{8'd55, 8'd2, 8'd255, 8'd128, 8'd200, 8'd0};
        logic [8:0] full;
        int         n;
        int         need;
        int         guard = 0;
        while (ready8 !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a8 = pa[0]; b8 = pb[0]; start8 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done8 !== 1'b1 && n < 40);
            full = {1'b0, pa[k]} - {1'b0, pb[k]};
            need = (k == 0) ? 9 : 10;
            tests++;
            if (n != need || d8 !== full[7:0] || bo8 !== (pa[k] < pb[k])) begin
                fails++;
                $display("FAIL b2b_%0d: gap=%0d d=%0d bo=%b, need gap=%0d d=%0d bo=%b",
                         k, n, d8, bo8, need, full[7:0], (pa[k] < pb[k]));
            end
            $display("[TB] b2b: %0d-%0d gap=%0d d=%0d bo=%b", pa[k], pb[k], n, d8, bo8);
            if (k < 5) begin
                a8 = pa[k+1]; b8 = pb[k+1];
            end else begin
                start8 = 1'b0;
            end
        end
    endtask

    task automatic test_width1();
        logic d;
        logic bo;
        int   lat;
        for (int i = 0; i < 4; i++) begin
            logic x, y;
            x = i[1];
            y = i[0];
            op1(x, y, d, bo, lat);
            tests++;
            if (lat != 2 || d !== (x ^ y) || bo !== (~x & y)) begin
                fails++;
                $display("FAIL w1: a=%b b=%b lat=%0d d=%b bo=%b, need lat=2 d=%b bo=%b",
                         x, y, lat, d, bo, x ^ y, ~x & y);
            end
            $display("[TB] width1: %b-%b d=%b bo=%b", x, y, d, bo);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore();
        test_reset_mid();
        test_width8_sweep();
        test_back_to_back();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
